// File: rtl/gray_step_tracker.sv
// gray_step_tracker: samples a 3-bit up/down Gray counter and converts it to binary.
// Each sampled change is classified as up, down, none or an illegal jump.
// Drives a wrapping position accumulator, a lap pulse and a sticky error flag.
// Optional build macro GRAY_STEP_SYNC_EN inserts a two-flop synchroniser on gray_in.
// The synchroniser adds 2 cycles to every latency.
module gray_step_tracker #(
  parameter int unsigned POS_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       gray_in,
  input  logic             clear,
  output logic [2:0]       bin,
  output logic             step_up,
  output logic             step_dn,
  output logic             lap,
  output logic             err,
  output logic             err_sticky,
  output logic [POS_W-1:0] position
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] B_MAX = CW'(7);
  localparam logic [CW-1:0] B_MIN = CW'(0);

  logic [CW-1:0] g_src;
  logic [CW-1:0] g_s;
  logic [CW-1:0] b_p;
  logic [CW-1:0] d_c;
  logic          up_c;
  logic          dn_c;
  logic          err_c;
  logic          lap_c;

`ifdef GRAY_STEP_SYNC_EN
  logic [CW-1:0] sync_q1;
  logic [CW-1:0] sync_q2;

  // Two-flop synchroniser for a gray_in that comes from an unrelated clock domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= gray_in;
      sync_q2 <= sync_q1;
    end
  end

  assign g_src = sync_q2;
`else
  assign g_src = gray_in;
`endif

  // Sample register for the Gray code and the previous binary value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_s <= '0;
      b_p <= '0;
    end else begin
      g_s <= g_src;
      b_p <= bin;
    end
  end

  // Gray to binary conversion of the sampled code
  assign bin = {g_s[2], g_s[2] ^ g_s[1], g_s[2] ^ g_s[1] ^ g_s[0]};

  // Classify the modulo-8 difference between the current and the previous binary value
  always_comb begin
    up_c  = 1'b0;
    dn_c  = 1'b0;
    err_c = 1'b0;
    d_c   = bin - b_p;
    case (d_c)
      CW'(0): ;
      CW'(1): up_c = 1'b1;
      CW'(7): dn_c = 1'b1;
      default: err_c = 1'b1;
    endcase
    lap_c = (up_c && (b_p == B_MAX) && (bin == B_MIN)) ||
            (dn_c && (b_p == B_MIN) && (bin == B_MAX));
  end

  // Registered pulses, position accumulator and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_up    <= 1'b0;
      step_dn    <= 1'b0;
      lap        <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      position   <= '0;
    end else begin
      step_up <= up_c;
      step_dn <= dn_c;
      lap     <= lap_c;
      err     <= err_c;
      // A coincident error outranks clear so that no error is ever lost
      err_sticky <= err_c | (err_sticky & ~clear);
      if (clear) begin
        position <= '0;
      end else if (up_c) begin
        position <= position + POS_W'(1);
      end else if (dn_c) begin
        position <= position - POS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gray_step_tracker.sv
// Directed bench for gray_step_tracker in the default build (no synchroniser), POS_W = 8.
// Pulses appear one edge after bin shows the value that caused them.
module tb_gray_step_tracker;

  localparam int unsigned POS_W = 8;

  logic             clk;
  logic             reset;
  logic [2:0]       gray_in;
  logic             clear;
  logic [2:0]       bin;
  logic             step_up;
  logic             step_dn;
  logic             lap;
  logic             err;
  logic             err_sticky;
  logic [POS_W-1:0] position;

  int n_cmp = 0;
  int n_bad = 0;

  gray_step_tracker #(.POS_W(POS_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_in    (gray_in),
    .clear      (clear),
    .bin        (bin),
    .step_up    (step_up),
    .step_dn    (step_dn),
    .lap        (lap),
    .err        (err),
    .err_sticky (err_sticky),
    .position   (position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one Gray code (and clear) ahead of the next rising edge, sample 1 time unit after it
  task automatic drive(input logic [2:0] g, input logic c);
    @(negedge clk);
    gray_in = g;
    clear   = c;
    @(posedge clk);
    #1;
  endtask

  // Pulse vector {step_up, step_dn, lap, err}
  function automatic logic [3:0] pulses();
    return {step_up, step_dn, lap, err};
  endfunction

  logic [2:0] lap_seq [8];
  int         lap_cnt;
  int         up_cnt;

  initial begin
    lap_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    reset   = 1'b0;
    gray_in = 3'b000;
    clear   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin", 32'(bin), 32'd0);
    chk("rst_pulses", 32'(pulses()), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_pos", 32'(position), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Forward full lap: bin 1..7,0 and eight up steps
    lap_cnt = 0;
    up_cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      drive(lap_seq[i], 1'b0);
      chk("fwd_bin", 32'(bin), 32'((i + 1) % 8));
      chk("fwd_err", 32'(err), 32'd0);
      if (step_up) up_cnt++;
      if (lap) lap_cnt++;
      if (i > 0) chk("fwd_pos", 32'(position), 32'(i));
    end
    drive(3'b000, 1'b0);
    chk("fwd_last_pulses", 32'(pulses()), 32'b1010);
    chk("fwd_pos8", 32'(position), 32'd8);
    if (step_up) up_cnt++;
    if (lap) lap_cnt++;
    drive(3'b000, 1'b0);
    chk("fwd_idle", 32'(pulses()), 32'd0);
    if (lap) lap_cnt++;
    chk("fwd_lap_count", 32'(lap_cnt), 32'd1);
    chk("fwd_up_count", 32'(up_cnt), 32'd8);

    // Illegal jump 0 -> 2, then a legal step 2 -> 3
    drive(3'b011, 1'b0);
    chk("jmp_bin", 32'(bin), 32'd2);
    drive(3'b010, 1'b0);
    chk("jmp_pulses", 32'(pulses()), 32'b0001);
    chk("jmp_pos", 32'(position), 32'd8);
    chk("jmp_sticky", 32'(err_sticky), 32'd1);
    drive(3'b010, 1'b0);
    chk("resync_pulses", 32'(pulses()), 32'b1000);
    chk("resync_pos", 32'(position), 32'd9);
    chk("resync_sticky", 32'(err_sticky), 32'd1);

    // Walk down 3 -> 2 -> 1 -> 0 -> 7, position 9 -> 5
    drive(3'b011, 1'b0);
    chk("dn_hold", 32'(pulses()), 32'd0);
    drive(3'b001, 1'b0);
    chk("dn1", 32'(pulses()), 32'b0100);
    drive(3'b000, 1'b0);
    drive(3'b100, 1'b0);
    chk("dn3_pos", 32'(position), 32'd6);
    drive(3'b000, 1'b0);
    chk("dn_lap", 32'(pulses()), 32'b0110);
    chk("dn_pos5", 32'(position), 32'd5);

    // Clear together with an up (7 -> 0) step
    drive(3'b000, 1'b1);
    chk("clr_up_pulses", 32'(pulses()), 32'b1010);
    chk("clr_up_pos", 32'(position), 32'd0);
    chk("clr_up_sticky", 32'(err_sticky), 32'd0);

    // Clear together with an error (0 -> 4)
    drive(3'b110, 1'b0);
    chk("pre_clr_err", 32'(pulses()), 32'd0);
    drive(3'b110, 1'b1);
    chk("clr_err_pulses", 32'(pulses()), 32'b0001);
    chk("clr_err_sticky", 32'(err_sticky), 32'd1);
    chk("clr_err_pos", 32'(position), 32'd0);

    // Hold 110 for 10 cycles: no pulses
    for (int i = 0; i < 10; i++) begin
      drive(3'b110, 1'b0);
      chk("hold_pulses", 32'(pulses()), 32'd0);
    end
    chk("hold_bin", 32'(bin), 32'd4);
    chk("hold_sticky", 32'(err_sticky), 32'd1);

    // Mid-operation reset between edges acts without a clock edge
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_bin", 32'(bin), 32'd0);
    chk("mid_rst_sticky", 32'(err_sticky), 32'd0);
    chk("mid_rst_pulses", 32'(pulses()), 32'd0);
    chk("mid_rst_pos", 32'(position), 32'd0);
    @(negedge clk);
    gray_in = 3'b000;
    @(negedge clk);
    reset = 1'b1;

    // Reverse underflow from reset: 0 -> 7 -> 6
    drive(3'b100, 1'b0);
    chk("rev_bin", 32'(bin), 32'd7);
    chk("rev_pre", 32'(pulses()), 32'd0);
    drive(3'b100, 1'b0);
    chk("rev_pulses", 32'(pulses()), 32'b0110);
    chk("rev_pos255", 32'(position), 32'd255);
    drive(3'b101, 1'b0);
    chk("rev_hold", 32'(pulses()), 32'd0);
    drive(3'b101, 1'b0);
    chk("rev2_pulses", 32'(pulses()), 32'b0100);
    chk("rev_pos254", 32'(position), 32'd254);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
